// File: rtl/display16_pkg.sv
// Shared types and constants for the 16-segment message sequencer.
// Character codes, segment patterns and scheduler states.
package display16_pkg;

    localparam int CHAR_W = 5;

    typedef logic [CHAR_W-1:0] code_t;
    typedef logic [15:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    localparam code_t C_BLANK = 5'd0;
    localparam code_t C_DASH  = 5'd1;
    localparam code_t C_A = 5'd2;
    localparam code_t C_B = 5'd3;
    localparam code_t C_C = 5'd4;
    localparam code_t C_D = 5'd5;
    localparam code_t C_E = 5'd6;
    localparam code_t C_F = 5'd7;
    localparam code_t C_G = 5'd8;
    localparam code_t C_H = 5'd9;
    localparam code_t C_I = 5'd10;
    localparam code_t C_J = 5'd11;
    localparam code_t C_K = 5'd12;
    localparam code_t C_L = 5'd13;
    localparam code_t C_M = 5'd14;
    localparam code_t C_N = 5'd15;
    localparam code_t C_O = 5'd16;
    localparam code_t C_P = 5'd17;
    localparam code_t C_Q = 5'd18;
    localparam code_t C_R = 5'd19;
    localparam code_t C_S = 5'd20;
    localparam code_t C_T = 5'd21;
    localparam code_t C_U = 5'd22;
    localparam code_t C_V = 5'd23;
    localparam code_t C_W = 5'd24;
    localparam code_t C_X = 5'd25;
    localparam code_t C_Y = 5'd26;
    localparam code_t C_Z = 5'd27;

    localparam seg_t SEG_BLANK = 16'h0000;
    localparam seg_t SEG_DASH  = 16'h0018;
    localparam seg_t SEG_A = 16'hF318;
    localparam seg_t SEG_B = 16'hFC52;
    localparam seg_t SEG_C = 16'hCF00;
    localparam seg_t SEG_D = 16'hFC42;
    localparam seg_t SEG_E = 16'hCF18;
    localparam seg_t SEG_F = 16'hC318;
    localparam seg_t SEG_G = 16'hDF10;
    localparam seg_t SEG_H = 16'h3318;
    localparam seg_t SEG_I = 16'hCC42;
    localparam seg_t SEG_J = 16'h3E00;
    localparam seg_t SEG_K = 16'h0325;
    localparam seg_t SEG_L = 16'h0F00;
    localparam seg_t SEG_M = 16'h33A0;
    localparam seg_t SEG_N = 16'h3381;
    localparam seg_t SEG_O = 16'hFF00;
    localparam seg_t SEG_P = 16'hE318;
    localparam seg_t SEG_Q = 16'hFF01;
    localparam seg_t SEG_R = 16'hE319;
    localparam seg_t SEG_S = 16'hDD18;
    localparam seg_t SEG_T = 16'hC042;
    localparam seg_t SEG_U = 16'h3F00;
    localparam seg_t SEG_V = 16'h0324;
    localparam seg_t SEG_W = 16'h3305;
    localparam seg_t SEG_X = 16'h00A5;
    localparam seg_t SEG_Y = 16'h00A2;
    localparam seg_t SEG_Z = 16'hCC24;

endpackage

// File: rtl/display16_scheduler_rom.sv
// Character code to 16-segment pattern decoder.
// Purely combinational; codes 28..31 decode as blank.
module seg16_char_rom
    import display16_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [15:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (code)
            C_DASH: seg = SEG_DASH;
            C_A:    seg = SEG_A;
            C_B:    seg = SEG_B;
            C_C:    seg = SEG_C;
            C_D:    seg = SEG_D;
            C_E:    seg = SEG_E;
            C_F:    seg = SEG_F;
            C_G:    seg = SEG_G;
            C_H:    seg = SEG_H;
            C_I:    seg = SEG_I;
            C_J:    seg = SEG_J;
            C_K:    seg = SEG_K;
            C_L:    seg = SEG_L;
            C_M:    seg = SEG_M;
            C_N:    seg = SEG_N;
            C_O:    seg = SEG_O;
            C_P:    seg = SEG_P;
            C_Q:    seg = SEG_Q;
            C_R:    seg = SEG_R;
            C_S:    seg = SEG_S;
            C_T:    seg = SEG_T;
            C_U:    seg = SEG_U;
            C_V:    seg = SEG_V;
            C_W:    seg = SEG_W;
            C_X:    seg = SEG_X;
            C_Y:    seg = SEG_Y;
            C_Z:    seg = SEG_Z;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display16_scheduler.sv
// Message sequencer: buffered characters shown with a programmable
// dwell, followed by one blank separator, then wrap or finish.
module display16_scheduler
    import display16_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DWELL_W = 24,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]  wr_char,
    input  logic [IDX_W:0]     msg_len,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   char_idx,
    output logic [15:0]        sal
);

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

    state_t state, state_n;

    logic [CHAR_W-1:0]  mem [DEPTH];
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_l, dwell_eff;
    logic [IDX_W:0]     len_l, len_eff;
    logic [IDX_W-1:0]   idx_n, idx_inc;
    logic [CHAR_W-1:0]  code_n;
    logic [15:0]        seg_n;
    logic               lit_n, done_n;
    logic               start_ok, last, cnt_zero;

    assign wr_ready  = (state == IDLE);
    assign start_ok  = (state == IDLE) && start && !stop && (msg_len != '0);
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign len_eff   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    assign idx_inc   = char_idx + IDX_W'(1);
    assign cnt_zero  = (cnt == '0);
    assign last      = ({1'b0, char_idx} == (len_l - (IDX_W+1)'(1)));

    seg16_char_rom u_rom (
        .code (code_n),
        .seg  (seg_n)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start_ok) state_n = SHOW;
            SHOW: begin
                if (stop)                state_n = IDLE;
                else if (cnt_zero && last) state_n = BLANK;
            end
            BLANK: begin
                if (stop)          state_n = IDLE;
                else if (cnt_zero) state_n = loop ? SHOW : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Next-value logic for the registered outputs and dwell counter
    always_comb begin
        idx_n  = char_idx;
        cnt_n  = cnt;
        code_n = mem[0];
        lit_n  = 1'b0;
        done_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    idx_n = '0;
                    cnt_n = dwell_eff - DWELL_W'(1);
                    lit_n = 1'b1;
                end
            end
            SHOW: begin
                if (stop) begin
                    idx_n = '0;
                    cnt_n = '0;
                end else if (!cnt_zero) begin
                    cnt_n  = cnt - DWELL_W'(1);
                    code_n = mem[char_idx];
                    lit_n  = 1'b1;
                end else if (last) begin
                    cnt_n = dwell_l - DWELL_W'(1);
                end else begin
                    idx_n  = idx_inc;
                    cnt_n  = dwell_l - DWELL_W'(1);
                    code_n = mem[idx_inc];
                    lit_n  = 1'b1;
                end
            end
            BLANK: begin
                if (stop) begin
                    idx_n = '0;
                    cnt_n = '0;
                end else if (!cnt_zero) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else if (loop) begin
                    idx_n = '0;
                    cnt_n = dwell_l - DWELL_W'(1);
                    lit_n = 1'b1;
                end else begin
                    idx_n  = '0;
                    cnt_n  = '0;
                    done_n = 1'b1;
                end
            end
            default: begin
                idx_n = '0;
                cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            char_idx <= '0;
            sal      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_l    <= '0;
            dwell_l  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            cnt      <= cnt_n;
            char_idx <= idx_n;
            sal      <= lit_n ? seg_n : 16'h0000;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            if (start_ok) begin
                len_l   <= len_eff;
                dwell_l <= dwell_eff;
            end
            if (wr_valid && wr_ready) mem[wr_addr] <= wr_char;
        end
    end

endmodule

// File: tb/tb_display16_scheduler.sv
// Directed self-checking bench for display16_scheduler.
// Inputs change 1 ns after the rising edge; outputs are checked there.
module tb_display16_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_char;
    logic [4:0]  msg_len;
    logic [23:0] dwell;
    logic        loop;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [3:0]  char_idx;
    logic [15:0] sal;

    int checks = 0;
    int errors = 0;

    display16_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .msg_len  (msg_len),
        .dwell    (dwell),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .char_idx (char_idx),
        .sal      (sal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] c);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_char  = c;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic go(input logic [4:0] len, input logic [23:0] dw);
        msg_len = len;
        dwell   = dw;
        start   = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] exp_sal [16];
    logic [3:0]  exp_idx [16];

    initial begin
        rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_char = 0;
        msg_len = 0; dwell = 0; loop = 0; start = 0; stop = 0;
        tick();
        rst = 1'b0;
        tick();

        // 1: reset after writes clears everything
        for (int i = 0; i < 4; i++) wr(4'(i), 5'($urandom_range(1, 27)));
        rst = 1'b1;
        tick();
        tick();
        chk("rst_sal", sal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", char_idx, 0);
        chk("rst_wr_ready", wr_ready, 1);
        rst = 1'b0;
        tick();
        go(1, 1);
        chk("t1_busy", busy, 1);
        chk("t1_blank_entry", sal, 0);
        tick();
        tick();
        chk("t1_done", done, 1);
        tick();

        // 2: three characters, dwell 4, no loop
        wr(0, 5); wr(1, 2); wr(2, 15);
        for (int k = 0; k < 16; k++) begin
            exp_sal[k] = (k < 4) ? 16'hFC42 : (k < 8) ? 16'hF318 :
                         (k < 12) ? 16'h3381 : 16'h0000;
            exp_idx[k] = (k < 4) ? 4'd0 : (k < 8) ? 4'd1 : 4'd2;
        end
        loop = 0;
        go(3, 4);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t2_sal%0d", k), sal, exp_sal[k]);
            chk($sformatf("t2_idx%0d", k), char_idx, exp_idx[k]);
            chk($sformatf("t2_busy%0d", k), busy, 1);
            chk($sformatf("t2_done%0d", k), done, 0);
            tick();
        end
        chk("t2_busy_end", busy, 0);
        chk("t2_done_end", done, 1);
        chk("t2_idx_end", char_idx, 0);
        tick();
        chk("t2_done_once", done, 0);

        // 3: loop of '-' then drop loop in the blank
        wr(0, 1);
        loop = 1;
        go(1, 2);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_sal%0d", k), sal,
                ((k % 4) < 2) ? 16'h0018 : 16'h0000);
            tick();
        end
        loop = 0;
        chk("t3_blank_sal", sal, 0);
        tick();
        chk("t3_busy_tail", busy, 1);
        chk("t3_sal_tail", sal, 0);
        tick();
        chk("t3_busy_end", busy, 0);
        chk("t3_done", done, 1);
        tick();

        // 4: write while busy ignored, then stop on cycle 3
        go(3, 4);
        chk("t4_wr_ready", wr_ready, 0);
        wr(1, 20);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_sal", sal, 0);
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_done", done, 0);
        chk("t4_stop_idx", char_idx, 0);
        go(2, 1);
        chk("t4_buf0", sal, 16'h0018);
        tick();
        chk("t4_buf1_kept", sal, 16'hF318);
        tick();
        tick();
        chk("t4_done", done, 1);
        tick();

        // 5: boundary starts
        go(0, 4);
        chk("t5_len0_busy", busy, 0);
        stop = 1'b1;
        go(1, 4);
        stop = 1'b0;
        chk("t5_startstop_busy", busy, 0);
        wr(15, 2);
        go(20, 0);
        chk("t5_c0", sal, 16'h0018);
        tick();
        chk("t5_c1", sal, 16'hF318);
        tick();
        chk("t5_c2", sal, 16'h3381);
        for (int k = 2; k < 15; k++) tick();
        chk("t5_idx15", char_idx, 15);
        chk("t5_sal15", sal, 16'hF318);
        tick();
        chk("t5_blank_idx", char_idx, 15);
        chk("t5_blank_sal", sal, 0);
        chk("t5_blank_busy", busy, 1);
        tick();
        chk("t5_done", done, 1);
        tick();

        // 6: reset during a looping blank
        loop = 1;
        go(1, 3);
        tick(); tick(); tick();
        chk("t6_in_blank", sal, 0);
        chk("t6_in_blank_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_sal", sal, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_idx", char_idx, 0);
        chk("t6_wr_ready", wr_ready, 1);
        loop = 0;
        go(1, 1);
        chk("t6_buf_cleared", sal, 0);
        tick();
        tick();
        chk("t6_done_after", done, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
